// File: rtl/aiv_sram_arbiter_if.sv
// Requester handshakes and SRAM pin bundle for aiv_sram_arbiter.
// The arbiter takes the slave modport; clients and the pad wrapper take master.
interface aiv_sram_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    logic              aux_req;
    logic              aux_we;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_wdata;
    logic              aux_ack;
    logic [DATA_W-1:0] aux_rdata;
    logic              aux_rvalid;

    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_out;
    logic [DATA_W-1:0] sram_dq_in;
    logic              sram_dq_oe;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  aux_req, aux_we, aux_addr, aux_wdata, sram_dq_in,
        output rd_ack, rd_data, rd_valid, wr_ack, aux_ack, aux_rdata, aux_rvalid,
        output sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output aux_req, aux_we, aux_addr, aux_wdata, sram_dq_in,
        input  rd_ack, rd_data, rd_valid, wr_ack, aux_ack, aux_rdata, aux_rvalid,
        input  sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
    );
endinterface

// File: rtl/aiv_sram_arbiter.sv
// Three-port framebuffer SRAM arbiter: fixed 3-cycle slots, rd > wr > aux with aux anti-starvation.
// Define AIV_SRAM_ARB_STATS_EN to add saturating grant/conflict counters.
module aiv_sram_arbiter #(
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 16,
    parameter int AUX_MAX_WAIT = 8
) (
    input  logic clk,
    input  logic reset,
`ifdef AIV_SRAM_ARB_STATS_EN
    input  logic        stat_clear,
    output logic [15:0] stat_rd_cnt,
    output logic [15:0] stat_wr_cnt,
    output logic [15:0] stat_aux_cnt,
    output logic [15:0] stat_conflict_cnt,
`endif
    aiv_sram_arbiter_if.slave bus
);
    typedef enum logic [2:0] {ST_IDLE, ST_A0, ST_A1, ST_A2, ST_TURN} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_RD, OWN_WR, OWN_AUX} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        aux_wait_q, aux_wait_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;
    logic              rd_valid_q, rd_valid_d;
    logic              aux_rvalid_q, aux_rvalid_d;
    logic              ce_n_q, ce_n_d;

    logic   decide;
    logic   aux_force;
    owner_t grant;
    logic   grant_we;
    logic   in_slot;

    always_comb begin
        decide    = (state_q == ST_IDLE) || (state_q == ST_A2);
        aux_force = bus.aux_req && (aux_wait_q >= 8'(AUX_MAX_WAIT));
        grant     = OWN_NONE;
        if (decide) begin
            if (aux_force)       grant = OWN_AUX;
            else if (bus.rd_req)  grant = OWN_RD;
            else if (bus.wr_req)  grant = OWN_WR;
            else if (bus.aux_req) grant = OWN_AUX;
        end
        grant_we = (grant == OWN_WR) || ((grant == OWN_AUX) && bus.aux_we);
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        aux_wait_d   = aux_wait_q;
        rd_data_d    = rd_data_q;
        aux_rdata_d  = aux_rdata_q;
        rd_valid_d   = 1'b0;
        aux_rvalid_d = 1'b0;
        ce_n_d       = 1'b0;

        case (state_q)
            ST_A0:   state_d = ST_A1;
            ST_A1:   state_d = ST_A2;
            ST_TURN: state_d = ST_A0;
            default: state_d = state_q;
        endcase

        // Only a write chained directly behind a read slot needs the dead cycle.
        if (decide) begin
            if (grant != OWN_NONE) begin
                state_d = ((state_q == ST_A2) && !we_q && grant_we) ? ST_TURN : ST_A0;
                owner_d = grant;
                we_d    = grant_we;
                case (grant)
                    OWN_RD:  addr_d = bus.rd_addr;
                    OWN_WR:  begin addr_d = bus.wr_addr;  wdata_d = bus.wr_data;   end
                    default: begin addr_d = bus.aux_addr; wdata_d = bus.aux_wdata; end
                endcase
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (!bus.aux_req || (grant == OWN_AUX)) begin
            aux_wait_d = '0;
        end else if ((grant != OWN_NONE) && (aux_wait_q < 8'(AUX_MAX_WAIT))) begin
            aux_wait_d = aux_wait_q + 8'd1;
        end

        if ((state_q == ST_A2) && !we_q) begin
            if (owner_q == OWN_RD) begin
                rd_data_d  = bus.sram_dq_in;
                rd_valid_d = 1'b1;
            end else if (owner_q == OWN_AUX) begin
                aux_rdata_d  = bus.sram_dq_in;
                aux_rvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            aux_wait_q   <= '0;
            rd_data_q    <= '0;
            aux_rdata_q  <= '0;
            rd_valid_q   <= 1'b0;
            aux_rvalid_q <= 1'b0;
            ce_n_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            aux_wait_q   <= aux_wait_d;
            rd_data_q    <= rd_data_d;
            aux_rdata_q  <= aux_rdata_d;
            rd_valid_q   <= rd_valid_d;
            aux_rvalid_q <= aux_rvalid_d;
            ce_n_q       <= ce_n_d;
        end
    end

    assign in_slot = (state_q == ST_A0) || (state_q == ST_A1) || (state_q == ST_A2);

    assign bus.rd_ack      = (state_q == ST_A0) && (owner_q == OWN_RD);
    assign bus.wr_ack      = (state_q == ST_A0) && (owner_q == OWN_WR);
    assign bus.aux_ack     = (state_q == ST_A0) && (owner_q == OWN_AUX);
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.aux_rdata   = aux_rdata_q;
    assign bus.aux_rvalid  = aux_rvalid_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_dq_out = wdata_q;
    assign bus.sram_dq_oe  = in_slot && we_q;
    assign bus.sram_oe_n   = !(in_slot && !we_q);
    assign bus.sram_we_n   = !((state_q == ST_A1) && we_q);
    assign bus.sram_ce_n   = ce_n_q;

`ifdef AIV_SRAM_ARB_STATS_EN
    logic [15:0] st_rd_q, st_rd_d, st_wr_q, st_wr_d;
    logic [15:0] st_aux_q, st_aux_d, st_conf_q, st_conf_d;
    logic [1:0]  pend_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    always_comb begin
        pend_cnt  = 2'(bus.rd_req) + 2'(bus.wr_req) + 2'(bus.aux_req);
        st_rd_d   = sat_inc(st_rd_q, bus.rd_ack);
        st_wr_d   = sat_inc(st_wr_q, bus.wr_ack);
        st_aux_d  = sat_inc(st_aux_q, bus.aux_ack);
        st_conf_d = sat_inc(st_conf_q, decide && (pend_cnt >= 2'd2));
        if (stat_clear) begin
            st_rd_d   = '0;
            st_wr_d   = '0;
            st_aux_d  = '0;
            st_conf_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_rd_q   <= '0;
            st_wr_q   <= '0;
            st_aux_q  <= '0;
            st_conf_q <= '0;
        end else begin
            st_rd_q   <= st_rd_d;
            st_wr_q   <= st_wr_d;
            st_aux_q  <= st_aux_d;
            st_conf_q <= st_conf_d;
        end
    end

    assign stat_rd_cnt       = st_rd_q;
    assign stat_wr_cnt       = st_wr_q;
    assign stat_aux_cnt      = st_aux_q;
    assign stat_conflict_cnt = st_conf_q;
`endif
endmodule

// File: tb/tb_aiv_sram_arbiter.sv
// Scoreboard bench for aiv_sram_arbiter: SRAM pin model, shadow memory updated in grant order,
// response monitor checking data and 3-cycle latency, plus directed protocol scenarios.
module tb_aiv_sram_arbiter;
    localparam int ADDR_W       = 18;
    localparam int DATA_W       = 16;
    localparam int AUX_MAX_WAIT = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    aiv_sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef AIV_SRAM_ARB_STATS_EN
    logic        stat_clear = 1'b0;
    logic [15:0] stat_rd_cnt, stat_wr_cnt, stat_aux_cnt, stat_conflict_cnt;
`endif

    aiv_sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AUX_MAX_WAIT(AUX_MAX_WAIT)) dut (
        .clk               (clk),
        .reset             (reset),
`ifdef AIV_SRAM_ARB_STATS_EN
        .stat_clear        (stat_clear),
        .stat_rd_cnt       (stat_rd_cnt),
        .stat_wr_cnt       (stat_wr_cnt),
        .stat_aux_cnt      (stat_aux_cnt),
        .stat_conflict_cnt (stat_conflict_cnt),
`endif
        .bus               (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic rst_prev = 1'b1;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t rd_q[$];
    exp_t aux_q[$];

    logic [15:0] mem    [int unsigned];
    logic [15:0] shadow [int unsigned];

    int rd_ack_cyc = 0, wr_ack_cyc = 0, aux_ack_cyc = 0;
    int oe_low_cnt = 0, we_low_cnt = 0, dqoe_cnt = 0;
    logic prev_oe_low = 1'b0;

    function automatic logic [15:0] init_val(input logic [17:0] a);
        if (a == 18'h00123) return 16'hBEEF;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] mem_rd(input logic [17:0] a);
        if (mem.exists(32'(a))) return mem[32'(a)];
        return init_val(a);
    endfunction

    function automatic logic [15:0] exp_rd(input logic [17:0] a);
        if (shadow.exists(32'(a))) return shadow[32'(a)];
        return init_val(a);
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= reset;
    end

    // Asynchronous-style SRAM: written while we_n is low, drives data while oe_n is low.
    always @(negedge clk) begin
        if (!bus.sram_we_n && !bus.sram_ce_n) mem[32'(bus.sram_addr)] = bus.sram_dq_out;
        bus.sram_dq_in = !bus.sram_oe_n ? mem_rd(bus.sram_addr) : 16'hA5A5;
    end

    // Monitor: scoreboard pushes on grant, pops on valid, and checks pin-level protocol.
    always @(negedge clk) begin
        exp_t e;
        if (bus.rd_valid) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_valid_unexpected actual=valid required=none (cycle %0d)", cyc);
            end else begin
                e = rd_q.pop_front();
                check_eq("rd_data", 32'(bus.rd_data), 32'(e.data));
                check_eq("rd_latency", cyc, e.cyc);
            end
        end else if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
            e = rd_q.pop_front();
            checks++; errors++;
            $display("FAIL rd_valid_missing actual=none required=valid_at_cycle_%0d", e.cyc);
        end
        if (bus.aux_rvalid) begin
            if (aux_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL aux_rvalid_unexpected actual=valid required=none (cycle %0d)", cyc);
            end else begin
                e = aux_q.pop_front();
                check_eq("aux_rdata", 32'(bus.aux_rdata), 32'(e.data));
                check_eq("aux_latency", cyc, e.cyc);
            end
        end else if (aux_q.size() != 0 && aux_q[0].cyc <= cyc) begin
            e = aux_q.pop_front();
            checks++; errors++;
            $display("FAIL aux_rvalid_missing actual=none required=valid_at_cycle_%0d", e.cyc);
        end

        if (bus.rd_ack) begin
            rd_ack_cyc = cyc;
            e.data = exp_rd(bus.rd_addr);
            e.cyc  = cyc + 3;
            rd_q.push_back(e);
        end
        if (bus.wr_ack) begin
            wr_ack_cyc = cyc;
            shadow[32'(bus.wr_addr)] = bus.wr_data;
        end
        if (bus.aux_ack) begin
            aux_ack_cyc = cyc;
            if (bus.aux_we) begin
                shadow[32'(bus.aux_addr)] = bus.aux_wdata;
            end else begin
                e.data = exp_rd(bus.aux_addr);
                e.cyc  = cyc + 3;
                aux_q.push_back(e);
            end
        end

        if (!rst_prev && !reset) begin
            checks++;
            if ($countones({bus.rd_ack, bus.wr_ack, bus.aux_ack}) > 1) begin
                errors++; $display("FAIL ack_onehot actual=%b required=at_most_one", {bus.rd_ack, bus.wr_ack, bus.aux_ack});
            end
            if (!bus.sram_oe_n && bus.sram_dq_oe) begin
                errors++; $display("FAIL bus_fight actual=oe_n0_dq_oe1 required=not_both (cycle %0d)", cyc);
            end
            if (!bus.sram_we_n && !bus.sram_dq_oe) begin
                errors++; $display("FAIL we_without_data actual=dq_oe0 required=dq_oe1 (cycle %0d)", cyc);
            end
            if (bus.sram_ce_n) begin
                errors++; $display("FAIL ce_n_active actual=1 required=0 (cycle %0d)", cyc);
            end
            if (prev_oe_low && bus.sram_dq_oe) begin
                errors++; $display("FAIL turnaround actual=dq_oe1_after_read required=dead_cycle (cycle %0d)", cyc);
            end
        end
        prev_oe_low = !bus.sram_oe_n;
        if (!bus.sram_oe_n) oe_low_cnt++;
        if (!bus.sram_we_n) we_low_cnt++;
        if (bus.sram_dq_oe) dqoe_cnt++;
    end

    task automatic do_rd(input logic [17:0] a);
        int n;
        bus.rd_addr = a;
        bus.rd_req  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rd_ack && n < 200);
        check_eq("rd_ack_seen", 32'(bus.rd_ack), 32'd1);
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
    endtask

    task automatic do_wr(input logic [17:0] a, input logic [15:0] d);
        int n;
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_req  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.wr_ack && n < 200);
        check_eq("wr_ack_seen", 32'(bus.wr_ack), 32'd1);
        @(posedge clk); #1;
        bus.wr_req = 1'b0;
    endtask

    task automatic do_aux(input logic we, input logic [17:0] a, input logic [15:0] d);
        int n;
        bus.aux_we    = we;
        bus.aux_addr  = a;
        bus.aux_wdata = d;
        bus.aux_req   = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.aux_ack && n < 200);
        check_eq("aux_ack_seen", 32'(bus.aux_ack), 32'd1);
        @(posedge clk); #1;
        bus.aux_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, t0, o0, w0, q0, rd_before;
        logic got_aux;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.aux_req = 1'b0; bus.aux_we = 1'b0; bus.aux_addr = '0; bus.aux_wdata = '0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_ce_n", 32'(bus.sram_ce_n), 32'd1);
        check_eq("reset_strobes", 32'({bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe}), 32'b110);
        check_eq("reset_acks_valids", 32'({bus.rd_ack, bus.wr_ack, bus.aux_ack, bus.rd_valid, bus.aux_rvalid}), 32'd0);
        check_eq("reset_sram_addr", 32'(bus.sram_addr), 32'd0);
        check_eq("reset_data_out", 32'({bus.rd_data, bus.aux_rdata}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);

        // Lone read
        t0 = cyc; o0 = oe_low_cnt;
        do_rd(18'h00123);
        check_eq("rd_ack_delay", rd_ack_cyc - t0, 1);
        idle(6);
        check_eq("rd_oe_cycles", oe_low_cnt - o0, 3);
        check_eq("rd_data_beef", 32'(bus.rd_data), 32'hBEEF);

        // Lone write
        w0 = we_low_cnt; q0 = dqoe_cnt;
        do_wr(18'h3FFFF, 16'h1234);
        idle(6);
        check_eq("wr_we_cycles", we_low_cnt - w0, 1);
        check_eq("wr_dqoe_cycles", dqoe_cnt - q0, 3);
        check_eq("wr_mem_3ffff", 32'(mem_rd(18'h3FFFF)), 32'h1234);

        // Simultaneous rd+wr: read first, TURN, then write
        fork
            do_rd(18'h00020);
            do_wr(18'h00020, 16'h7777);
        join
        idle(8);
        check_eq("collide_rd_first", 32'(wr_ack_cyc > rd_ack_cyc), 32'd1);
        check_eq("collide_turn_gap", wr_ack_cyc - rd_ack_cyc, 4);
        check_eq("collide_mem", 32'(mem_rd(18'h00020)), 32'h7777);

        // Aux starvation bound with rd held continuously
        bus.rd_addr = 18'h00005; bus.rd_req = 1'b1;
        bus.aux_addr = 18'h00009; bus.aux_we = 1'b0; bus.aux_req = 1'b1;
        n = 0; rd_before = 0; got_aux = 1'b0;
        while (!got_aux && n < 200) begin
            @(negedge clk); n++;
            if (bus.rd_ack) rd_before++;
            if (bus.aux_ack) got_aux = 1'b1;
        end
        check_eq("aux_granted", 32'(got_aux), 32'd1);
        check_eq("aux_lost_decisions", rd_before, AUX_MAX_WAIT);
        @(posedge clk); #1;
        bus.aux_req = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(bus.rd_ack || bus.wr_ack || bus.aux_ack) && n < 20);
        check_eq("rd_resumes", 32'({bus.rd_ack, bus.wr_ack, bus.aux_ack}), 32'b100);
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
        idle(8);

        // Reset during write A1
        bus.wr_addr = 18'h2AAAA; bus.wr_data = 16'hCAFE; bus.wr_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.wr_ack && n < 50);
        check_eq("rst_wr_ack_seen", 32'(bus.wr_ack), 32'd1);
        @(posedge clk); #1;
        bus.wr_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_strobes", 32'({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe}), 32'b1110);
        check_eq("abort_acks_valids", 32'({bus.rd_ack, bus.wr_ack, bus.aux_ack, bus.rd_valid, bus.aux_rvalid}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);
        do_wr(18'h00777, 16'h5678);
        idle(6);
        check_eq("post_reset_write", 32'(mem_rd(18'h00777)), 32'h5678);

        fork
            do_rd(18'h00030);
            do_wr(18'h00031, 16'h3131);
        join
        do_rd(18'h00031);
        do_rd(18'h00777);
        idle(8);
`ifdef AIV_SRAM_ARB_STATS_EN
        check_eq("stat_rd", 32'(stat_rd_cnt), 32'd3);
        check_eq("stat_wr", 32'(stat_wr_cnt), 32'd2);
        check_eq("stat_aux", 32'(stat_aux_cnt), 32'd0);
        check_eq("stat_conflict", 32'(stat_conflict_cnt), 32'd1);
        stat_clear = 1'b1;
        idle(1);
        stat_clear = 1'b0;
        @(negedge clk);
        check_eq("stat_cleared", 32'(stat_rd_cnt | stat_wr_cnt | stat_aux_cnt | stat_conflict_cnt), 32'd0);
        idle(1);
`endif

        // Randomized concurrent traffic over a small address window
        fork
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                do_rd(18'($urandom_range(0, 63)));
            end
            for (int j = 0; j < 30; j++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                do_wr(18'($urandom_range(0, 63)), 16'($urandom));
            end
            for (int k = 0; k < 30; k++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                do_aux(1'($urandom_range(0, 1)), 18'($urandom_range(0, 63)), 16'($urandom));
            end
        join
        idle(10);
        check_eq("rd_queue_drained", rd_q.size(), 0);
        check_eq("aux_queue_drained", aux_q.size(), 0);
        for (int unsigned a = 0; a < 64; a++) begin
            if (shadow.exists(a)) check_eq("final_mem", 32'(mem_rd(18'(a))), 32'(shadow[a]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
